morse_encoder: RTL and testbench

Morse transmitter: accepts one character code per valid/ready handshake and keys it out on a single on/off line with standard Morse unit timing. Dot = 1 unit mark, dash = 3, intra-character gap = 1, inter-character gap = 3, word space = 7. Counterpart to the Morse decoder path; drives the key/LED/buzzer output that the decoder's timing front end measures.

---
 rtl/morse_encoder.sv | 158 +++++++++++++++
 tb/tb_morse_encoder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/morse_encoder.sv
// Morse keyer: one character per handshake, keyed out with standard unit timing scaled by mode+1.
// Define MORSE_DIGITS_EN to enable digit codes 26-35; otherwise they are rejected like invalid codes.
module morse_encoder #(
  parameter int UNIT_CYCLES = 25000
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [5:0] in_code,
  input  logic [1:0] mode,
  output logic       in_ready,
  output logic       key_out,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MARK = 3'd1;
  localparam logic [2:0] S_GAP  = 3'd2;
  localparam logic [2:0] S_CGAP = 3'd3;
  localparam logic [2:0] S_WGAP = 3'd4;

  localparam int TICK_W = $clog2(UNIT_CYCLES);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(UNIT_CYCLES - 1);

  logic [2:0]        state, state_nx;
  logic [TICK_W-1:0] tick;
  logic [1:0]        mcnt, k;
  logic [2:0]        ucnt, eidx, seg_last;
  logic [4:0]        pat;
  logic [7:0]        rom;
  logic              rom_char, rom_space, seg_end, take;

  // ROM entry = {length, pattern}; pattern is right-aligned, first element in bit length-1, 1 = dash
  always_comb begin
    rom = 8'd0;
    case (in_code)
      6'd0:  rom = {3'd2, 5'b00001};
      6'd1:  rom = {3'd4, 5'b01000};
      6'd2:  rom = {3'd4, 5'b01010};
      6'd3:  rom = {3'd3, 5'b00100};
      6'd4:  rom = {3'd1, 5'b00000};
      6'd5:  rom = {3'd4, 5'b00010};
      6'd6:  rom = {3'd3, 5'b00110};
      6'd7:  rom = {3'd4, 5'b00000};
      6'd8:  rom = {3'd2, 5'b00000};
      6'd9:  rom = {3'd4, 5'b00111};
      6'd10: rom = {3'd3, 5'b00101};
      6'd11: rom = {3'd4, 5'b00100};
      6'd12: rom = {3'd2, 5'b00011};
      6'd13: rom = {3'd2, 5'b00010};
      6'd14: rom = {3'd3, 5'b00111};
      6'd15: rom = {3'd4, 5'b00110};
      6'd16: rom = {3'd4, 5'b01101};
      6'd17: rom = {3'd3, 5'b00010};
      6'd18: rom = {3'd3, 5'b00000};
      6'd19: rom = {3'd1, 5'b00001};
      6'd20: rom = {3'd3, 5'b00001};
      6'd21: rom = {3'd4, 5'b00001};
      6'd22: rom = {3'd3, 5'b00011};
      6'd23: rom = {3'd4, 5'b01001};
      6'd24: rom = {3'd4, 5'b01011};
      6'd25: rom = {3'd4, 5'b01100};
`ifdef MORSE_DIGITS_EN
      6'd26: rom = {3'd5, 5'b11111};
      6'd27: rom = {3'd5, 5'b01111};
      6'd28: rom = {3'd5, 5'b00111};
      6'd29: rom = {3'd5, 5'b00011};
      6'd30: rom = {3'd5, 5'b00001};
      6'd31: rom = {3'd5, 5'b00000};
      6'd32: rom = {3'd5, 5'b10000};
      6'd33: rom = {3'd5, 5'b11000};
      6'd34: rom = {3'd5, 5'b11100};
      6'd35: rom = {3'd5, 5'b11110};
`endif
      default: rom = 8'd0;
    endcase
  end

  assign rom_char  = (rom[7:5] != 3'd0);
  assign rom_space = (in_code == 6'd36);
  assign take      = (state == S_IDLE) && in_valid && (rom_char || rom_space);

  // Last unit index of the current segment; a segment ends when all three counters hit their limits
  always_comb begin
    seg_last = 3'd0;
    case (state)
      S_MARK:  seg_last = pat[eidx] ? 3'd2 : 3'd0;
      S_CGAP:  seg_last = 3'd2;
      S_WGAP:  seg_last = 3'd6;
      default: seg_last = 3'd0;
    endcase
  end

  assign seg_end = (state != S_IDLE) && (tick == TICK_LAST) && (mcnt == k) && (ucnt == seg_last);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (take) state_nx = rom_char ? S_MARK : S_WGAP;
      S_MARK: if (seg_end) state_nx = (eidx != 3'd0) ? S_GAP : S_CGAP;
      S_GAP:  if (seg_end) state_nx = S_MARK;
      S_CGAP, S_WGAP: if (seg_end) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state    <= S_IDLE;
      tick     <= '0;
      mcnt     <= 2'd0;
      ucnt     <= 3'd0;
      eidx     <= 3'd0;
      k        <= 2'd0;
      key_out  <= 1'b0;
      in_ready <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nx;
      key_out  <= (state_nx == S_MARK);
      in_ready <= (state_nx == S_IDLE);
      busy     <= (state_nx != S_IDLE);
      done     <= ((state == S_CGAP) || (state == S_WGAP)) && seg_end;
      err      <= (state == S_IDLE) && in_valid && !rom_char && !rom_space;
      if ((state == S_IDLE) || seg_end) begin
        tick <= '0;
        mcnt <= 2'd0;
        ucnt <= 3'd0;
      end else if (tick == TICK_LAST) begin
        tick <= '0;
        if (mcnt == k) begin
          mcnt <= 2'd0;
          ucnt <= ucnt + 3'd1;
        end else begin
          mcnt <= mcnt + 2'd1;
        end
      end else begin
        tick <= tick + 1'b1;
      end
      if (take) begin
        k    <= mode;
        eidx <= rom_char ? (rom[7:5] - 3'd1) : 3'd0;
      end else if ((state == S_MARK) && seg_end && (eidx != 3'd0)) begin
        eidx <= eidx - 3'd1;
      end
    end
  end

  // Element pattern is only consulted in MARK, so it needs no reset
  always_ff @(posedge clock) begin
    if (take) pat <= rom[4:0];
  end

endmodule

// File: tb/tb_morse_encoder.sv
// Bench for morse_encoder: a dot/dash string model predicts every output cycle, plus literal timing checks.
module tb_morse_encoder;

  localparam int UC = 4;

  logic       clock = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [5:0] in_code = 6'd0;
  logic [1:0] mode = 2'd0;
  logic       in_ready, key_out, busy, done, err;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  morse_encoder #(.UNIT_CYCLES(UC)) dut (
    .clock(clock), .rst(rst), .in_valid(in_valid), .in_code(in_code), .mode(mode),
    .in_ready(in_ready), .key_out(key_out), .busy(busy), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  string morse_tab [36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                            "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                            "..-", "...-", ".--", "-..-", "-.--", "--..",
                            "-----", ".----", "..---", "...--", "....-",
                            ".....", "-....", "--...", "---..", "----."};

  function automatic bit char_ok(input int c);
`ifdef MORSE_DIGITS_EN
    return (c >= 0) && (c <= 35);
`else
    return (c >= 0) && (c <= 25);
`endif
  endfunction

  // Reference model: expected key level for each cycle after acceptance, queued up front
  bit   exp_q[$];
  logic exp_key = 1'b0, exp_ready = 1'b1, exp_busy = 1'b0, exp_done = 1'b0, exp_err = 1'b0;

  always @(posedge clock) begin
    int c, u, n;
    string s;
    if (rst) begin
      exp_q.delete();
      exp_key = 1'b0; exp_ready = 1'b1; exp_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
    end else begin
      exp_done = 1'b0;
      exp_err  = 1'b0;
      if (!exp_busy && in_valid) begin
        c = int'(in_code);
        u = (int'(mode) + 1) * UC;
        if (c == 36) begin
          repeat (7 * u) exp_q.push_back(1'b0);
        end else if (char_ok(c)) begin
          s = morse_tab[c];
          for (int i = 0; i < s.len(); i++) begin
            n = (s[i] == "-") ? 3 : 1;
            repeat (n * u) exp_q.push_back(1'b1);
            if (i != s.len() - 1) repeat (u) exp_q.push_back(1'b0);
          end
          repeat (3 * u) exp_q.push_back(1'b0);
        end else begin
          exp_err = 1'b1;
        end
      end
      if (exp_q.size() > 0) begin
        exp_key = exp_q.pop_front();
        exp_busy = 1'b1; exp_ready = 1'b0;
      end else begin
        if (exp_busy) exp_done = 1'b1;
        exp_key = 1'b0; exp_busy = 1'b0; exp_ready = 1'b1;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      checks++;
      if ({key_out, in_ready, busy, done, err} !== {exp_key, exp_ready, exp_busy, exp_done, exp_err}) begin
        errors++;
        $display("FAIL cycle_compare t=%0t got key/rdy/busy/done/err=%b%b%b%b%b expected %b%b%b%b%b",
                 $time, key_out, in_ready, busy, done, err, exp_key, exp_ready, exp_busy, exp_done, exp_err);
      end
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Presents one code at a negedge, scrambles mode afterwards, and measures key-high cycles and done position
  task automatic run_char(input int code, input int md, input string nm, input int exp_hi, input int exp_dn);
    int hi, cyc;
    bit seen;
    in_valid = 1'b1; in_code = 6'(code); mode = 2'(md);
    @(negedge clock);
    in_valid = 1'b0; mode = 2'($urandom_range(0, 3));
    hi = 0; seen = 1'b0; cyc = 0;
    while (cyc < 2000) begin
      if (done === 1'b1) begin seen = 1'b1; break; end
      if (key_out === 1'b1) hi++;
      @(negedge clock);
      cyc++;
    end
    check({nm, "_key_high"}, hi, exp_hi);
    check({nm, "_done_cycle"}, seen ? cyc : -1, exp_dn);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int r, c, w;
    @(posedge clock);
    chk_en = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_key", int'(key_out), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    rst = 1'b0;
    @(negedge clock);

    run_char(4, 0, "E", 4, 16);
    run_char(0, 0, "A", 16, 32);
    run_char(19, 0, "T_b2b", 12, 24);
    run_char(19, 1, "T_x2", 24, 48);
    run_char(36, 0, "space", 0, 28);

    in_valid = 1'b1; in_code = 6'd40;
    @(negedge clock);
    check("inv_err", int'(err), 1);
    check("inv_ready", int'(in_ready), 1);
    check("inv_busy", int'(busy), 0);
    @(negedge clock);
    check("inv_err_held", int'(err), 1);
    in_valid = 1'b0;
    @(negedge clock);
    check("inv_err_clear", int'(err), 0);

`ifdef MORSE_DIGITS_EN
    run_char(26, 0, "digit0", 60, 88);
`else
    in_valid = 1'b1; in_code = 6'd26;
    @(negedge clock);
    in_valid = 1'b0;
    check("digit_err", int'(err), 1);
    check("digit_busy", int'(busy), 0);
    @(negedge clock);
    check("digit_nokey", int'(key_out), 0);
`endif

    in_valid = 1'b1; in_code = 6'd0; mode = 2'd0;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (9) @(negedge clock);
    check("A_mark2_key", int'(key_out), 1);
    rst = 1'b1;
    @(negedge clock);
    rst = 1'b0;
    check("midrst_key", int'(key_out), 0);
    check("midrst_ready", int'(in_ready), 1);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    @(negedge clock);
    check("midrst_no_done", int'(done), 0);
    run_char(4, 0, "E_after_rst", 4, 16);

    for (int it = 0; it < 50; it++) begin
      r = $urandom_range(0, 9);
      if (r < 6)       c = $urandom_range(0, 25);
      else if (r == 6) c = $urandom_range(26, 35);
      else if (r == 7) c = 36;
      else if (r == 8) c = $urandom_range(37, 63);
      else             c = $urandom_range(0, 63);
      w = 0;
      while (exp_ready !== 1'b1 && w < 2000) begin @(negedge clock); w++; end
      if (w >= 2000) check("wait_ready_timeout", 0, 1);
      in_valid = 1'b1; in_code = 6'(c); mode = 2'($urandom_range(0, 3));
      @(negedge clock);
      in_valid = 1'b0;
      w = 0;
      while (exp_busy === 1'b1 && w < 2000) begin
        in_valid = 1'($urandom_range(0, 1));
        in_code  = 6'($urandom_range(0, 63));
        mode     = 2'($urandom_range(0, 3));
        if (w == 20 && $urandom_range(0, 11) == 0) rst = 1'b1;
        @(negedge clock);
        rst = 1'b0;
        w++;
      end
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end

    @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
